// File: rtl/otter_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otter_if_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
package otter_if_pkg;

  localparam int XLEN = 32;

  // Canonical NOP (addi x0, x0, 0) presented by an empty or trapped stage
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // REQ : request is being presented to instruction memory
  // WAIT: request accepted, response outstanding
  // HOLD: fetched instruction parked in the hold register for decode
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage : otter_if_pkg
`default_nettype wire

// File: rtl/if_fetch_stage_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_reg
//  Description : Architectural program-counter register with write enable
//                and asynchronous active-low reset to RESET_PC.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_reg
  import otter_if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN-1:0] pc_q;

  // Load a new PC only when enabled; reset returns to the boot address
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else if (we_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule : pc_reg
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_stage
//  Description : Instruction-fetch stage. Holds the PC, issues one
//                instruction-memory request at a time (req/gnt/rvalid),
//                and presents the fetched instruction to decode over a
//                valid/ready interface. REDIRECT squashes work in flight.
//  Options     : IF_MISALIGN_TRAP_EN - adds IF_MISALIGN; a misaligned PC is
//                not fetched but delivered as a flagged NOP.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_stage
  import otter_if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [XLEN-1:0] PC_MUX_OUT,
  input  logic            REDIRECT,
  output logic [XLEN-1:0] PC_OUT,
  output logic [XLEN-1:0] PC_OUT_PLUS_FOUR,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [XLEN-1:0] IMEM_RDATA,
  output logic            IF_VALID,
  input  logic            IF_READY,
  output logic [XLEN-1:0] IF_PC,
  output logic [XLEN-1:0] IF_INSTR
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic            IF_MISALIGN
`endif
);

  fetch_state_t    state_q, state_d;
  logic            discard_q, discard_d;
  logic            hold_valid_q, hold_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic            fire;
  logic            misaligned;
`ifdef IF_MISALIGN_TRAP_EN
  logic            misalign_q, misalign_d;
`endif

  // A redirect cycle never hands an instruction to decode
  assign IF_VALID         = hold_valid_q & ~REDIRECT;
  assign fire             = IF_VALID & IF_READY;
  assign PC_OUT_PLUS_FOUR = PC_OUT + 32'd4;
  assign IMEM_ADDR        = PC_OUT;
  assign IF_PC            = if_pc_q;
  assign IF_INSTR         = if_instr_q;

`ifdef IF_MISALIGN_TRAP_EN
  assign misaligned  = (PC_OUT[1:0] != 2'b00);
  assign IF_MISALIGN = misalign_q;
`else
  assign misaligned  = 1'b0;
`endif

  assign IMEM_REQ = (state_q == REQ) & ~misaligned;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .we_i   (fire | REDIRECT),
    .d_i    (PC_MUX_OUT),
    .q_o    (PC_OUT)
  );

  // Fetch sequencing: request, wait for the response, hold for decode
  always_comb begin
    state_d      = state_q;
    discard_d    = discard_q;
    hold_valid_d = hold_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
`ifdef IF_MISALIGN_TRAP_EN
    misalign_d   = misalign_q;
`endif
    case (state_q)
      REQ: begin
        if (misaligned) begin
          // Trap path: deliver a flagged NOP instead of touching memory
          if (!REDIRECT) begin
            state_d      = HOLD;
            hold_valid_d = 1'b1;
            if_pc_d      = PC_OUT;
            if_instr_d   = NOP_INSTR;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_d   = 1'b1;
`endif
          end
        end else if (IMEM_GNT) begin
          // A grant alongside a redirect is still accepted; its data is stale
          state_d   = WAIT;
          discard_d = REDIRECT;
        end
      end
      WAIT: begin
        if (IMEM_RVALID) begin
          if (discard_q || REDIRECT) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            if_pc_d      = PC_OUT;
            if_instr_d   = IMEM_RDATA;
            hold_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (REDIRECT) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (REDIRECT || fire) begin
          hold_valid_d = 1'b0;
          state_d      = REQ;
`ifdef IF_MISALIGN_TRAP_EN
          misalign_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // State and hold-register update; reset empties the stage
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= REQ;
      discard_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= NOP_INSTR;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      hold_valid_q <= hold_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

endmodule : if_fetch_stage
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_stage
//  Description : Self-checking bench for if_fetch_stage. The bench acts as
//                PC mux, instruction memory and decode; a reference model
//                tracks the PC of the next instruction decode must receive.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_mux_out;
  logic        redirect;
  logic [31:0] pc_out, pc_out_plus_four;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
`ifdef IF_MISALIGN_TRAP_EN
  logic        if_misalign;
`endif

  if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .CLK              (clk),
    .RST_N            (rst_n),
    .PC_MUX_OUT       (pc_mux_out),
    .REDIRECT         (redirect),
    .PC_OUT           (pc_out),
    .PC_OUT_PLUS_FOUR (pc_out_plus_four),
    .IMEM_REQ         (imem_req),
    .IMEM_ADDR        (imem_addr),
    .IMEM_GNT         (imem_gnt),
    .IMEM_RVALID      (imem_rvalid),
    .IMEM_RDATA       (imem_rdata),
    .IF_VALID         (if_valid),
    .IF_READY         (if_ready),
    .IF_PC            (if_pc),
    .IF_INSTR         (if_instr)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .IF_MISALIGN      (if_misalign)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Stimulus knobs (percentages) and one-shot overrides
  int          p_gnt = 100, p_rdy = 100, p_redir = 0, p_spur = 0, max_dly = 0;
  bit          force_redir = 1'b0;
  logic [31:0] force_tgt = '0;
  bit          force_data_en = 1'b0;
  logic [31:0] force_data = '0;
  bit          hold_resp = 1'b0;

  // Memory model and reference model state
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          dly = 0;
  logic [31:0] exp_pc = RESET_PC;
  int          delivered = 0;

  // Observations from the most recent cycle
  logic        o_req, o_gnt, o_rv, o_valid, o_fire;
  logic [31:0] o_addr, o_pc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Instruction memory content: a scrambled function of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // One clock: drive after the rising edge, observe and check at the falling edge
  task automatic step();
    logic        redir;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    if (pend && !hold_resp && dly == 0) begin
      imem_rvalid   = 1'b1;
      imem_rdata    = force_data_en ? force_data : mem_word(pend_addr);
      force_data_en = 1'b0;
    end else begin
      if (pend && dly > 0) dly--;
      imem_rvalid = !pend && ($urandom_range(0, 99) < p_spur);
      imem_rdata  = $urandom();
    end
    imem_gnt    = ($urandom_range(0, 99) < p_gnt);
    if_ready    = ($urandom_range(0, 99) < p_rdy);
    redir       = force_redir || ($urandom_range(0, 99) < p_redir);
    tgt         = force_redir ? force_tgt : ($urandom() & 32'hFFFF_FFFC);
    force_redir = 1'b0;
    redirect    = redir;
    pc_mux_out  = redir ? tgt : pc_out_plus_four;

    @(negedge clk);
    o_req   = imem_req;
    o_addr  = imem_addr;
    o_gnt   = imem_gnt;
    o_rv    = imem_rvalid;
    o_valid = if_valid;
    o_fire  = if_valid & if_ready;
    o_pc    = if_pc;

    check("pc_out", pc_out, exp_pc);
    check("pc_plus4", pc_out_plus_four, exp_pc + 32'd4);
    if (imem_req) check("imem_addr", imem_addr, exp_pc);
    check("one_outstanding", imem_req & pend, 1'b0);
    if (redir) check("valid_on_redirect", if_valid, 1'b0);
    if (if_valid) begin
      check("if_pc", if_pc, exp_pc);
      check("if_instr", if_instr, mem_word(exp_pc));
    end

    if (imem_rvalid && pend) pend = 1'b0;
    if (imem_req && imem_gnt) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      dly       = $urandom_range(0, max_dly);
    end
    if (redir) begin
      exp_pc = tgt;
    end else if (o_fire) begin
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
  endtask

  initial begin
    logic [8:0]  v_req, v_rv, v_valid;
    logic [31:0] snap_pc, snap_instr, snap_pcout;
    bit          found;

    rst_n = 1'b0; redirect = 1'b0; pc_mux_out = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_pc_out", pc_out, RESET_PC);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, NOP);
    check("rst_imem_req", imem_req, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back fetch at minimum latency
    v_req = '0; v_rv = '0; v_valid = '0;
    for (int i = 0; i < 9; i++) begin
      step();
      v_req   = {v_req[7:0], o_req};
      v_rv    = {v_rv[7:0], o_rv};
      v_valid = {v_valid[7:0], o_valid};
    end
    check("lat_req_pattern", {23'd0, v_req}, 32'b100100100);
    check("lat_rvalid_pattern", {23'd0, v_rv}, 32'b010010010);
    check("lat_valid_pattern", {23'd0, v_valid}, 32'b001001001);
    check("lat_delivered", delivered, 3);

    // Decode back-pressure: hold register must stay put
    p_rdy = 0;
    o_valid = 1'b0;
    for (int i = 0; i < 10 && !o_valid; i++) step();
    check("hold_reached", o_valid, 1'b1);
    snap_pc = if_pc; snap_instr = if_instr; snap_pcout = pc_out;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", o_valid, 1'b1);
      check("hold_if_pc", if_pc, snap_pc);
      check("hold_if_instr", if_instr, snap_instr);
      check("hold_no_req", o_req, 1'b0);
      check("hold_pc_out", pc_out, snap_pcout);
    end
    p_rdy = 100;
    step();
    check("hold_release_fire", o_fire, 1'b1);

    // Redirect while the response is outstanding
    hold_resp = 1'b1;
    o_req = 1'b0; o_gnt = 1'b0;
    for (int i = 0; i < 10 && !(o_req && o_gnt); i++) step();
    check("wait_granted", o_req & o_gnt, 1'b1);
    force_redir = 1'b1; force_tgt = 32'h0000_0100;
    step();
    check("wait_redir_valid", o_valid, 1'b0);
    hold_resp = 1'b0; force_data_en = 1'b1; force_data = 32'hDEAD_BEEF;
    step();
    check("drop_rvalid_seen", o_rv, 1'b1);
    check("drop_valid", o_valid, 1'b0);
    step();
    check("drop_valid_after", o_valid, 1'b0);
    check("redir100_req", o_req, 1'b1);
    check("redir100_addr", o_addr, 32'h0000_0100);

    // Redirect in the cycle the instruction would be accepted
    step();
    check("hold_rv_0x100", o_rv, 1'b1);
    force_redir = 1'b1; force_tgt = 32'h0000_0200;
    step();
    check("squash_valid", o_valid, 1'b0);
    step();
    check("redir200_req", o_req, 1'b1);
    check("redir200_addr", o_addr, 32'h0000_0200);

    // Asynchronous reset with a response outstanding
    hold_resp = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0;
    #1;
    check("async_rst_pc", pc_out, RESET_PC);
    check("async_rst_valid", if_valid, 1'b0);
    pend = 1'b0; hold_resp = 1'b0; exp_pc = RESET_PC;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_req", o_req, 1'b1);
    check("post_rst_addr", o_addr, RESET_PC);

    // PC wrap-around at the top of the address space
    force_redir = 1'b1; force_tgt = 32'hFFFF_FFFC;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (o_fire && o_pc == 32'hFFFF_FFFC) found = 1'b1;
    end
    check("wrap_fetched", found, 1'b1);
    step();
    check("wrap_req", o_req, 1'b1);
    check("wrap_addr", o_addr, 32'h0000_0000);

    // Randomized traffic against the reference model
    p_gnt = 60; p_rdy = 60; p_redir = 8; p_spur = 10; max_dly = 3;
    delivered = 0;
    for (int i = 0; i < 3000; i++) step();
    check("progress", delivered >= 50, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_if_fetch_stage
`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that consumes the next-PC value produced by the PC-select multiplexer.
- Holds the architectural PC register and returns PC_OUT / PC_OUT_PLUS_FOUR to the mux.
- Issues one instruction-memory request at a time over a req/gnt/rvalid handshake.
- Presents the fetched instruction to decode through a valid/ready interface; supports redirect (squash) from jumps and branches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- PC_MUX_OUT  in  32  next PC from the PC-select mux.
- REDIRECT  in  1  high when the PC select is non-sequential (JALR/BRANCH/JAL); squashes fetch in progress.
- PC_OUT  out  32  current PC register.
- PC_OUT_PLUS_FOUR  out  32  PC_OUT + 4, modulo 2^32, combinational.
- IMEM_REQ  out  1  memory request valid.
- IMEM_ADDR  out  32  request address; equals PC_OUT.
- IMEM_GNT  in  1  request accepted this cycle.
- IMEM_RVALID  in  1  response data valid.
- IMEM_RDATA  in  32  response instruction.
- IF_VALID  out  1  IF_INSTR/IF_PC valid to decode.
- IF_READY  in  1  decode accepts.
- IF_PC  out  32  PC of the presented instruction.
- IF_INSTR  out  32  presented instruction.

Behaviour:
- Reset, asynchronous, active low:
  - PC_OUT = RESET_PC.
  - State = REQ.
  - IF_VALID = 0, IF_PC = 0, IF_INSTR = 32'h0000_0013 (NOP).
  - discard flag = 0.
- FSM states: REQ, WAIT, HOLD.
  - REQ: IMEM_REQ = 1. On IMEM_GNT, go to WAIT.
  - WAIT: IMEM_REQ = 0, at most one outstanding request. On IMEM_RVALID:
    - discard = 0: capture IMEM_RDATA into IF_INSTR and PC_OUT into IF_PC, then go to HOLD.
    - discard = 1: drop the data, clear discard, then go to REQ.
  - HOLD: hold register is full. IF_VALID = hold_valid & ~REDIRECT (combinational gate). On fire (IF_VALID & IF_READY), go to REQ.
- PC update:
  - PC_OUT <= PC_MUX_OUT when fire | REDIRECT.
  - Otherwise PC_OUT holds.
  - Sequential advance relies on the mux selecting PC_OUT_PLUS_FOUR when REDIRECT = 0.
- Latency: GNT in the same cycle as REQ, RVALID the next cycle, IF_VALID the cycle after that. Minimum 3 cycles per instruction.
- REDIRECT, by state:
  - REQ: the address changes to the new PC next cycle. IMEM_ADDR is otherwise stable while IMEM_REQ = 1 and GNT = 0. A GNT in the same cycle as REDIRECT is treated as accepted; go to WAIT with discard = 1.
  - WAIT: set discard = 1. If RVALID arrives in the same cycle, drop that data and go directly to REQ.
  - HOLD: the instruction is squashed. IF_VALID is 0 this cycle, hold_valid clears, go to REQ.
  - REDIRECT takes precedence over IF_READY. There is no fire in a redirect cycle.
- Wrap-around: PC 32'hFFFF_FFFC + 4 = 32'h0000_0000. No overflow flag.
- IMEM_RVALID outside WAIT is ignored.
- A reset asserted mid-transaction abandons the outstanding response. The memory side must tolerate this; the response is never consumed.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- Defined:
  - Extra output IF_MISALIGN (1 bit).
  - In REQ with PC_OUT[1:0] != 0: no IMEM_REQ is issued.
  - Go directly to HOLD with IF_INSTR = NOP and IF_MISALIGN = 1; IF_MISALIGN clears on fire or redirect.
- Undefined:
  - The port is absent and PC[1:0] is ignored.
  - Misaligned addresses are issued as-is.

Decomposition:
- Shared package otter_if_pkg:
  - fetch_state_t enum {REQ, WAIT, HOLD}.
  - NOP_INSTR = 32'h0000_0013.
  - XLEN = 32.
- One natural sub-module, pc_reg: async active-low reset to RESET_PC, write enable, 32-bit. Instantiated once.
- FSM and hold register stay in if_fetch_stage.

Test Plan:
- Reset release with GNT = 1 and RVALID 1 cycle later, IF_READY = 1:
  - IMEM_ADDR sequence 0x0, 0x4, 0x8.
  - IF_PC matches each address; IF_VALID one cycle after each RVALID.
- IF_READY = 0 for 5 cycles in HOLD:
  - IF_VALID stays 1; IF_INSTR/IF_PC stable; IMEM_REQ = 0; PC_OUT unchanged.
- REDIRECT to 0x100 while in WAIT, then RVALID with 0xDEADBEEF:
  - Data is dropped and IF_VALID never rises for it.
  - Next IMEM_ADDR = 0x100.
- REDIRECT to 0x200 in the same cycle as IF_VALID = 1 and IF_READY = 1:
  - IF_VALID reads 0 in that cycle.
  - Next request is at 0x200, not at the old PC + 4.
- PC = 0xFFFF_FFFC fetched and accepted: next IMEM_ADDR = 0x0000_0000.
- RST_N dropped in WAIT, asynchronously mid-cycle:
  - PC_OUT = RESET_PC and IF_VALID = 0 immediately.
  - After release, a fresh request at RESET_PC.
